fifo_read_packer: RTL and testbench

- Read-side consumer for the team's synchronous FIFO.
- Drives the FIFO read enable and captures the FIFO's registered read data.
- Packs Lanes consecutive Width-bit entries into one wide word and presents it on a valid/ready output stream.
- A flush request forces out a partial word with a byte-lane keep mask. Sits between a byte FIFO and a wide datapath such as a bus master or DMA.

---
 rtl/fifo_read_packer.sv | 66 ++++++
 tb/tb_fifo_read_packer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_packer.sv
// fifo_read_packer: pops a FIFO and packs Lanes entries into one wide valid/ready word,
// with flush emitting a partial word and a per-lane keep mask.
module fifo_read_packer #(
  parameter int Width = 8,
  parameter int Lanes = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  output logic                     fifo_r_en,
  input  logic [Width-1:0]         fifo_data,
  input  logic                     flush,
  output logic [Width*Lanes-1:0]   out_data,
  output logic [Lanes-1:0]         out_keep,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);
  localparam int FW = $clog2(Lanes) + 1;
  typedef enum logic {FILL, FLUSH} state_t;
  state_t                   state;
  logic [FW-1:0]            fill;
  logic                     pending;
  logic [Width*Lanes-1:0]   pack;
  logic                     out_free, xfer, settle;
  logic [Lanes-1:0]         keep;
  // Counting the in-flight pop keeps fill+pending from ever overrunning the pack register.
  assign fifo_r_en = !rst && !fifo_empty && state == FILL && (fill + FW'(pending)) < FW'(Lanes);
  assign out_free  = !out_valid || out_ready;
  assign settle    = state == FLUSH && !pending && out_free;
  assign xfer      = out_free && !pending && (state == FILL ? fill == FW'(Lanes) : fill != '0);
  assign busy      = fill != '0 || pending || state == FLUSH || out_valid;
  always_comb begin
    keep = '0;
    for (int i = 0; i < Lanes; i++) keep[i] = FW'(i) < fill;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      fill      <= '0;
      pending   <= 1'b0;
      pack      <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
    end else begin
      pending <= fifo_r_en && !fifo_empty;
      if (xfer) begin
        out_data  <= pack;
        out_keep  <= keep;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer || settle) begin
        pack <= '0;
        fill <= '0;
      end else if (pending) begin
        for (int i = 0; i < Lanes; i++)
          if (fill == FW'(i)) pack[i*Width +: Width] <= fifo_data;
        fill <= fill + 1'b1;
      end
      state <= settle ? FILL : (state == FILL && flush) ? FLUSH : state;
    end
  end
endmodule

// File: tb/tb_fifo_read_packer.sv
// tb_fifo_read_packer: directed scenarios against a behavioural FIFO with registered read data.
module tb_fifo_read_packer;
  logic        clk, rst, fifo_empty, fifo_r_en, flush, out_valid, out_ready, busy;
  logic [7:0]  fifo_data;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic [7:0]  mem [0:127];
  int          wr, rd, pops, p0, checks, passed;
  logic [31:0] bd [$];
  logic [3:0]  bk [$];

  fifo_read_packer #(.Width(8), .Lanes(4)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
    .fifo_data(fifo_data), .flush(flush), .out_data(out_data), .out_keep(out_keep),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (rd == wr);
  initial begin rd = 0; pops = 0; fifo_data = 8'h00; end
  always @(posedge clk)
    if (fifo_r_en && !fifo_empty) begin
      fifo_data <= mem[rd];
      rd        <= rd + 1;
      pops      <= pops + 1;
    end

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      bd.push_back(out_data);
      bk.push_back(out_keep);
    end

  task tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task push(input logic [7:0] b);
    mem[wr] = b;
    wr++;
  endtask

  task clear();
    bd.delete();
    bk.delete();
    p0 = pops;
  endtask

  task test_reset();
    push(8'h99);
    tick(1);
    checks++; if (fifo_r_en !== 1'b0) $display("FAIL rst_r_en: got %b want 0", fifo_r_en); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passed++;
    checks++; if (out_data !== 32'h0) $display("FAIL rst_data: got %h want 0", out_data); else passed++;
    checks++; if (out_keep !== 4'h0) $display("FAIL rst_keep: got %h want 0", out_keep); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    checks++; if (pops !== 0) $display("FAIL rst_pops: got %0d want 0", pops); else passed++;
    wr = rd;
    rst = 1'b0;
    tick(1);
  endtask

  task test_basic();
    out_ready = 1'b1;
    clear();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(12);
    checks++; if (bd.size() !== 1) $display("FAIL basic_beats: got %0d want 1", bd.size()); else passed++;
    checks++; if (bd[0] !== 32'h44332211) $display("FAIL basic_data: got %h want 44332211", bd[0]); else passed++;
    checks++; if (bk[0] !== 4'hf) $display("FAIL basic_keep: got %h want f", bk[0]); else passed++;
    checks++; if (pops - p0 !== 4) $display("FAIL basic_pops: got %0d want 4", pops - p0); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", busy); else passed++;
  endtask

  task test_backpressure();
    out_ready = 1'b0;
    clear();
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(20);
    checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", out_valid); else passed++;
    checks++; if (out_data !== 32'h04030201) $display("FAIL bp_data: got %h want 04030201", out_data); else passed++;
    checks++; if (out_keep !== 4'hf) $display("FAIL bp_keep: got %h want f", out_keep); else passed++;
    checks++; if (pops - p0 !== 8) $display("FAIL bp_pops: got %0d want 8", pops - p0); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", busy); else passed++;
    tick(5);
    checks++; if (out_data !== 32'h04030201) $display("FAIL bp_stable: got %h want 04030201", out_data); else passed++;
    checks++; if (pops - p0 !== 8) $display("FAIL bp_pops_hold: got %0d want 8", pops - p0); else passed++;
    out_ready = 1'b1;
    tick(4);
    checks++; if (bd.size() !== 2) $display("FAIL bp_beats: got %0d want 2", bd.size()); else passed++;
    checks++; if (bd[0] !== 32'h04030201) $display("FAIL bp_beat0: got %h want 04030201", bd[0]); else passed++;
    checks++; if (bd[1] !== 32'h08070605) $display("FAIL bp_beat1: got %h want 08070605", bd[1]); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_idle: got %b want 0", out_valid); else passed++;
  endtask

  task test_flush_partial();
    clear();
    push(8'hAA); push(8'hBB);
    tick(6);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(4);
    checks++; if (bd.size() !== 1) $display("FAIL fp_beats: got %0d want 1", bd.size()); else passed++;
    checks++; if (bd[0] !== 32'h0000BBAA) $display("FAIL fp_data: got %h want 0000bbaa", bd[0]); else passed++;
    checks++; if (bk[0] !== 4'b0011) $display("FAIL fp_keep: got %b want 0011", bk[0]); else passed++;
    clear();
    push(8'hCC); push(8'hDD); push(8'hEE); push(8'hFF);
    tick(12);
    checks++; if (bd.size() !== 1) $display("FAIL fp_next_beats: got %0d want 1", bd.size()); else passed++;
    checks++; if (bd[0] !== 32'hFFEEDDCC) $display("FAIL fp_next_data: got %h want ffeeddcc", bd[0]); else passed++;
    checks++; if (bk[0] !== 4'hf) $display("FAIL fp_next_keep: got %h want f", bk[0]); else passed++;
  endtask

  task test_flush_empty();
    clear();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL fe_in_flush: got busy %b want 1", busy); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL fe_valid0: got %b want 0", out_valid); else passed++;
    tick(1);
    checks++; if (busy !== 1'b0) $display("FAIL fe_back_fill: got busy %b want 0", busy); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL fe_valid1: got %b want 0", out_valid); else passed++;
    checks++; if (bd.size() !== 0) $display("FAIL fe_beats: got %0d want 0", bd.size()); else passed++;
  endtask

  task test_flush_pending();
    clear();
    push(8'h61); push(8'h62); push(8'h63);
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(5);
    checks++; if (bd.size() !== 1) $display("FAIL fpend_beats: got %0d want 1", bd.size()); else passed++;
    checks++; if (bd[0] !== 32'h00636261) $display("FAIL fpend_data: got %h want 00636261", bd[0]); else passed++;
    checks++; if (bk[0] !== 4'b0111) $display("FAIL fpend_keep: got %b want 0111", bk[0]); else passed++;
    checks++; if (pops - p0 !== 3) $display("FAIL fpend_pops: got %0d want 3", pops - p0); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL fpend_busy: got %b want 0", busy); else passed++;
  endtask

  task test_reset_mid();
    out_ready = 1'b0;
    clear();
    for (int i = 8'h71; i <= 8'h77; i++) push(8'(i));
    tick(20);
    checks++; if (out_data !== 32'h74737271) $display("FAIL rm_pre_data: got %h want 74737271", out_data); else passed++;
    checks++; if (pops - p0 !== 7) $display("FAIL rm_pre_pops: got %0d want 7", pops - p0); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", out_valid); else passed++;
    checks++; if (out_data !== 32'h0) $display("FAIL rm_data: got %h want 0", out_data); else passed++;
    checks++; if (out_keep !== 4'h0) $display("FAIL rm_keep: got %h want 0", out_keep); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else passed++;
    tick(2);
    rst = 1'b0;
    out_ready = 1'b1;
    tick(1);
    clear();
    push(8'h55); push(8'h56); push(8'h57); push(8'h58);
    tick(12);
    checks++; if (bd.size() !== 1) $display("FAIL rm_beats: got %0d want 1", bd.size()); else passed++;
    checks++; if (bd[0] !== 32'h58575655) $display("FAIL rm_post_data: got %h want 58575655", bd[0]); else passed++;
    checks++; if (bk[0] !== 4'hf) $display("FAIL rm_post_keep: got %h want f", bk[0]); else passed++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; wr = 0; checks = 0; passed = 0;
    tick(2);
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_partial();
    test_flush_empty();
    test_flush_pending();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
